// File: rtl/dma_mem_master.sv
// DMA initiator on the shared memory's DMA port: streams len words from src out on m_*,
// and writes len words taken from s_* to dst, sharing the single memory port between both.
module dma_mem_master #(
   parameter int RD_LAT     = 11,
   parameter int FIFO_DEPTH = 16,
   parameter int LEN_W      = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [31:0]      src_addr,
   input  logic [31:0]      dst_addr,
   input  logic [LEN_W-1:0] len,
   output logic             busy,
   output logic             done,
   output logic             mem_en,
   output logic             mem_we,
   output logic [31:0]      mem_addr,
   output logic [31:0]      mem_wdata,
   input  logic [31:0]      mem_rdata,
   input  logic             mem_rd_ack,
   output logic [31:0]      m_tdata,
   output logic             m_tvalid,
   input  logic             m_tready,
   output logic             m_tlast,
   input  logic [31:0]      s_tdata,
   input  logic             s_tvalid,
   output logic             s_tready
);
   localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = AW + 1;
   localparam int SW = CW + 1;
   // Reads in flight are bounded by the return latency and by the buffer credit.
   localparam int OUTS_MAX = (RD_LAT + 1 < FIFO_DEPTH) ? RD_LAT + 1 : FIFO_DEPTH;
   localparam int OW = $clog2(OUTS_MAX + 1);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t           r_state, w_state_nxt;
   logic [31:0]      r_src, r_dst;
   logic [LEN_W-1:0] r_len, r_rd_iss, r_wr_iss, r_rd_out;
   logic [OW-1:0]    r_outs;
   logic [31:0]      r_fifo [FIFO_DEPTH];
   logic [AW-1:0]    r_wptr, r_rptr;
   logic [CW-1:0]    r_count;
   logic             r_last_wr;

   logic w_accept, w_rd_gnt, w_wr_gnt, w_pop, w_credit, w_rd_elig, w_wr_elig;

   // Credit counts both buffered words and reads still in flight, so returns never overflow.
   assign w_credit  = ({1'b0, r_count} + SW'(r_outs)) < SW'(FIFO_DEPTH);
   assign w_rd_elig = (r_state == S_RUN) && (r_rd_iss < r_len) && w_credit;
   assign w_wr_elig = (r_state == S_RUN) && (r_wr_iss < r_len) && s_tvalid;
   assign w_pop     = m_tvalid && m_tready;

   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      busy        = 1'b0;
      done        = 1'b0;
      w_accept    = 1'b0;
      w_rd_gnt    = 1'b0;
      w_wr_gnt    = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_accept    = 1'b1;
               w_state_nxt = (len == '0) ? S_DONE : S_RUN;
            end
         end
         S_RUN: begin
            busy     = 1'b1;
            // On conflict the side that lost last time wins.
            w_rd_gnt = w_rd_elig && (!w_wr_elig || r_last_wr);
            w_wr_gnt = w_wr_elig && !w_rd_gnt;
            if (r_rd_out == r_len && r_wr_iss == r_len) w_state_nxt = S_DONE;
         end
         S_DONE: begin
            busy        = 1'b1;
            done        = 1'b1;
            w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_rd_iss  <= '0;
         r_wr_iss  <= '0;
         r_rd_out  <= '0;
         r_outs    <= '0;
         r_wptr    <= '0;
         r_rptr    <= '0;
         r_count   <= '0;
         r_last_wr <= 1'b1;
      end else begin
         if (w_accept) begin
            r_rd_iss <= '0;
            r_wr_iss <= '0;
            r_rd_out <= '0;
         end else begin
            if (w_rd_gnt) r_rd_iss <= r_rd_iss + LEN_W'(1);
            if (w_wr_gnt) r_wr_iss <= r_wr_iss + LEN_W'(1);
            if (w_pop)    r_rd_out <= r_rd_out + LEN_W'(1);
         end
         case ({w_rd_gnt, mem_rd_ack})
            2'b10:   r_outs <= r_outs + OW'(1);
            2'b01:   r_outs <= r_outs - OW'(1);
            default: ;
         endcase
         if (mem_rd_ack) r_wptr <= r_wptr + AW'(1);
         if (w_pop)      r_rptr <= r_rptr + AW'(1);
         case ({mem_rd_ack, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: ;
         endcase
         if (w_rd_elig && w_wr_elig) r_last_wr <= w_wr_gnt;
      end
   end

   always_ff @(posedge clk) begin
      if (w_accept) begin
         r_src <= src_addr;
         r_dst <= dst_addr;
         r_len <= len;
      end
      if (mem_rd_ack) r_fifo[r_wptr] <= mem_rdata;
   end

   assign mem_en    = w_rd_gnt || w_wr_gnt;
   assign mem_we    = w_wr_gnt;
   assign mem_addr  = w_rd_gnt ? r_src + (32'(r_rd_iss) << 2) :
                      w_wr_gnt ? r_dst + (32'(r_wr_iss) << 2) : 32'd0;
   assign mem_wdata = w_wr_gnt ? s_tdata : 32'd0;
   assign s_tready  = w_wr_gnt;

   assign m_tvalid  = (r_count != '0);
   assign m_tdata   = r_fifo[r_rptr];
   assign m_tlast   = m_tvalid && (r_rd_out == r_len - LEN_W'(1));

endmodule
